// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transfer scheduler.
// Contents:
//   SPI_BITS - bits shifted per byte by the spi_master
//   STATE_W  - width of the scheduler state encoding
//   state_t  - scheduler states (IDLE=0 .. GAP=4)
package spi_ctrl_pkg;

  localparam int SPI_BITS = 8;
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/spi_xfer_scheduler_rr_arbiter.sv
// Round-robin requester picker, purely combinational.
// Ports:
//   req     - per-requester request bits
//   ptr     - index the upward scan starts from (wraps at N_REQ)
//   gnt_idx - first requesting index at or after ptr
//   any     - at least one request is present
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int KW    = IDX_W + 1;

  logic [KW-1:0] w_k;

  // Scan from the highest offset down so the smallest offset from ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_k     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_k = {1'b0, ptr} + KW'(i);
      if (w_k >= KW'(N_REQ)) begin
        w_k = w_k - KW'(N_REQ);
      end else begin
        w_k = w_k;
      end
      if (req[w_k[IDX_W-1:0]]) begin
        gnt_idx = w_k[IDX_W-1:0];
        any     = 1'b1;
      end else begin
        any     = any;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Sequences a shared spi_master byte shifter between several requesters.
// One requester owns the shifter per packet (round-robin at packet
// boundaries); each byte is fetched, loaded for one cycle, then shifted for
// SPI_BITS cycles while start_o keeps chip-select asserted for the packet.
// Ports:
//   clk_i, areset_i           - clock, asynchronous active-high reset
//   req_valid/last/data_i     - per-requester byte streams (data k at [8k+7:8k])
//   req_ready_o               - one-hot accept to the granted requester
//   start_o, load_o, data_o   - spi_master controls
//   grant_o                   - current or last owner
//   busy_o, done_o, err_o     - not-idle, packet done pulse, stall abort pulse
module spi_xfer_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 2,
  parameter int STALL_MAX  = 16
) (
  input  logic                     clk_i,
  input  logic                     areset_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_last_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     start_o,
  output logic                     load_o,
  output logic [SPI_BITS-1:0]      data_o,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int IDX_W     = $clog2(N_REQ);
  localparam int BIT_W     = $clog2(SPI_BITS);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LIM   = GAP_CYCLES - 1;
  localparam int STALL_W   = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam int STALL_LIM = (STALL_MAX > 0) ? STALL_MAX - 1 : 0;

  state_t               r_state,  w_state_nx;
  logic [IDX_W-1:0]     r_grant,  w_grant_nx;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_nx;
  logic                 r_in_pkt, w_in_pkt_nx;
  logic                 r_last,   w_last_nx;
  logic [SPI_BITS-1:0]  r_data,   w_data_nx;
  logic [BIT_W-1:0]     r_bitcnt, w_bit_nx;
  logic [STALL_W-1:0]   r_stall,  w_stall_nx;
  logic [GAP_W-1:0]     r_gap,    w_gap_nx;

  logic                 r_start,  w_start_nx;
  logic                 r_load,   w_load_nx;
  logic [N_REQ-1:0]     r_ready,  w_ready_nx;
  logic                 r_busy,   w_busy_nx;
  logic                 r_done,   w_done_nx;
  logic                 r_err,    w_err_nx;

  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_any;
  logic [IDX_W-1:0]     w_grant_inc;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid_i),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_arb_idx),
    .any     (w_arb_any)
  );

  // Pointer the next arbitration starts from once the current owner is done.
  always_comb begin
    if (r_grant == IDX_W'(N_REQ - 1)) begin
      w_grant_inc = '0;
    end else begin
      w_grant_inc = r_grant + IDX_W'(1);
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    w_state_nx  = r_state;
    w_grant_nx  = r_grant;
    w_rr_nx     = r_rr_ptr;
    w_in_pkt_nx = r_in_pkt;
    w_last_nx   = r_last;
    w_data_nx   = r_data;
    w_bit_nx    = r_bitcnt;
    w_stall_nx  = r_stall;
    w_gap_nx    = r_gap;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) begin
          w_state_nx  = ST_FETCH;
          w_grant_nx  = w_arb_idx;
          w_in_pkt_nx = 1'b0;
          w_stall_nx  = '0;
        end else begin
          w_state_nx  = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (req_valid_i[r_grant]) begin
          w_data_nx  = req_data_i[{r_grant, 3'b000} +: SPI_BITS];
          w_last_nx  = req_last_i[r_grant];
          w_state_nx = ST_LOAD;
          w_stall_nx = '0;
        end else if (r_in_pkt && (STALL_MAX > 0)) begin
          // Mid-packet starvation: CS is held, so bound how long we wait.
          if (r_stall == STALL_W'(STALL_LIM)) begin
            w_state_nx  = ST_GAP;
            w_err_nx    = 1'b1;
            w_rr_nx     = w_grant_inc;
            w_gap_nx    = '0;
            w_in_pkt_nx = 1'b0;
          end else begin
            w_stall_nx  = r_stall + STALL_W'(1);
          end
        end else begin
          w_state_nx = ST_FETCH;
        end
      end
      ST_LOAD: begin
        w_state_nx = ST_SHIFT;
        w_bit_nx   = '0;
      end
      ST_SHIFT: begin
        if (r_bitcnt == BIT_W'(SPI_BITS - 1)) begin
          if (r_last) begin
            w_state_nx  = ST_GAP;
            w_done_nx   = 1'b1;
            w_rr_nx     = w_grant_inc;
            w_gap_nx    = '0;
            w_in_pkt_nx = 1'b0;
          end else begin
            w_state_nx  = ST_FETCH;
            w_in_pkt_nx = 1'b1;
            w_stall_nx  = '0;
          end
        end else begin
          w_bit_nx = r_bitcnt + BIT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(GAP_LIM)) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_gap_nx   = r_gap + GAP_W'(1);
        end
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_in_pkt_nx = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    w_load_nx  = (w_state_nx == ST_LOAD);
    w_busy_nx  = (w_state_nx != ST_IDLE);
    // The first FETCH of a packet keeps CS high-gap; later FETCHes hold CS low.
    w_start_nx = (w_state_nx == ST_LOAD) || (w_state_nx == ST_SHIFT) ||
                 ((w_state_nx == ST_FETCH) && w_in_pkt_nx);
    if (w_state_nx == ST_FETCH) begin
      w_ready_nx = N_REQ'(1) << w_grant_nx;
    end else begin
      w_ready_nx = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_in_pkt <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_bitcnt <= '0;
      r_stall  <= '0;
      r_gap    <= '0;
      r_start  <= 1'b0;
      r_load   <= 1'b0;
      r_ready  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_rr_ptr <= w_rr_nx;
      r_in_pkt <= w_in_pkt_nx;
      r_last   <= w_last_nx;
      r_data   <= w_data_nx;
      r_bitcnt <= w_bit_nx;
      r_stall  <= w_stall_nx;
      r_gap    <= w_gap_nx;
      r_start  <= w_start_nx;
      r_load   <= w_load_nx;
      r_ready  <= w_ready_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_err    <= w_err_nx;
    end
  end

  assign req_ready_o = r_ready;
  assign start_o     = r_start;
  assign load_o      = r_load;
  assign data_o      = r_data;
  assign grant_o     = r_grant;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Self-checking bench for spi_xfer_scheduler: a per-cycle vector table for a
// single-byte packet, then hand-written sequences for multi-byte packets,
// arbitration, stalls/aborts, mid-packet reset and a one-cycle GAP variant.
module tb_spi_xfer_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset_i;
  logic [1:0]  req_valid_i, req_last_i, req_ready_o;
  logic [15:0] req_data_i;
  logic        start_o, load_o, busy_o, done_o, err_o;
  logic [7:0]  data_o;
  logic [0:0]  grant_o;

  logic [1:0]  g_valid, g_last, g_ready;
  logic [15:0] g_data;
  logic        g_start, g_load, g_busy, g_done, g_err;
  logic [7:0]  g_data_o;
  logic [0:0]  g_grant;

  spi_xfer_scheduler #(.N_REQ(2), .GAP_CYCLES(2), .STALL_MAX(16)) dut (
    .clk_i(clk), .areset_i(areset_i), .req_valid_i(req_valid_i),
    .req_last_i(req_last_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .start_o(start_o), .load_o(load_o), .data_o(data_o), .grant_o(grant_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  spi_xfer_scheduler #(.N_REQ(2), .GAP_CYCLES(1), .STALL_MAX(16)) dut_g1 (
    .clk_i(clk), .areset_i(areset_i), .req_valid_i(g_valid),
    .req_last_i(g_last), .req_data_i(g_data), .req_ready_o(g_ready),
    .start_o(g_start), .load_o(g_load), .data_o(g_data_o), .grant_o(g_grant),
    .busy_o(g_busy), .done_o(g_done), .err_o(g_err));

  typedef struct packed {
    logic       start, load, done, err, busy;
    logic [1:0] ready;
    logic       grant;
    logic [7:0] data;
    logic       g_start;
  } obs_t;

  typedef struct {
    logic [1:0]  v, l;
    logic [15:0] d;
    logic [15:0] exp;   // {start,load,busy,done,err,ready[1:0],grant,data[7:0]}
  } vec_t;

  int         n_chk = 0, n_pass = 0, n_bad_ready = 0;
  obs_t       tr[$];
  logic [8:0] q0[$], q1[$];    // {last, data}
  logic [1:0] hold = 2'b00;
  logic [1:0] hs;
  vec_t       tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [15:0] d,
                              input logic s, input logic ld, input logic b, input logic dn,
                              input logic e, input logic [1:0] rdy, input logic [7:0] dat);
    vec_t r;
    r.v = v; r.l = l; r.d = d;
    r.exp = {s, ld, b, dn, e, rdy, 1'b0, dat};
    return r;
  endfunction

  task automatic drive();
    hold = hold;
    if (q0.size() > 0) begin
      req_valid_i[0] = ~hold[0]; req_last_i[0] = q0[0][8]; req_data_i[7:0] = q0[0][7:0];
    end else begin
      req_valid_i[0] = 1'b0; req_last_i[0] = 1'b0; req_data_i[7:0] = 8'h00;
    end
    if (q1.size() > 0) begin
      req_valid_i[1] = ~hold[1]; req_last_i[1] = q1[0][8]; req_data_i[15:8] = q1[0][7:0];
    end else begin
      req_valid_i[1] = 1'b0; req_last_i[1] = 1'b0; req_data_i[15:8] = 8'h00;
    end
  endtask

  // Record this cycle's outputs, then advance one clock.
  task automatic tick();
    obs_t o;
    o.start = start_o; o.load = load_o; o.done = done_o; o.err = err_o; o.busy = busy_o;
    o.ready = req_ready_o; o.grant = grant_o; o.data = data_o; o.g_start = g_start;
    tr.push_back(o);
    if (req_ready_o != 2'b00 && req_ready_o != (2'b01 << grant_o)) n_bad_ready++;
    hs = req_ready_o & req_valid_i;
    @(posedge clk); #1;
  endtask

  task automatic tick_f();
    logic [8:0] dmy;
    tick();
    if (hs[0] && q0.size() > 0) dmy = q0.pop_front();
    if (hs[1] && q1.size() > 0) dmy = q1.pop_front();
    drive();
  endtask

  function automatic int nth_load(input int n);
    int c = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].load) begin
        if (c == n) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int run_len(input int idx);
    int k = 0;
    if (idx < 0) return -1;
    while (idx + k < tr.size() && tr[idx + k].start) k++;
    return k;
  endfunction

  task automatic wait_loads(input int n, input int budget, input string name);
    int k = 0;
    while (nth_load(n - 1) < 0 && k < budget) begin tick_f(); k++; end
    if (nth_load(n - 1) < 0) check(name, 32'(k), 32'(budget + 1));
  endtask

  task automatic wait_ready0(input int budget, input string name);
    int k = 0;
    while (!req_ready_o[0] && k < budget) begin tick_f(); k++; end
    check(name, 32'(req_ready_o[0]), 32'd1);
  endtask

  task automatic chk_load(input string name, input int n, input logic g, input logic [7:0] d);
    int idx = nth_load(n);
    if (idx < 0) check(name, 32'hFFFF_FFFF, {23'd0, g, d});
    else         check(name, {23'd0, tr[idx].grant, tr[idx].data}, {23'd0, g, d});
  endtask

  task automatic do_reset();
    areset_i = 1'b1; q0.delete(); q1.delete(); hold = 2'b00; drive();
    tick(); tick();
    areset_i = 1'b0;
  endtask

  initial begin
    int idx, c0, h, z1, z2, p, nerr;
    logic [7:0] exp_d[8];
    logic       exp_g[8];

    // --- reset state ---
    g_valid = 2'b00; g_last = 2'b00; g_data = 16'h0000;
    areset_i = 1'b1; drive();
    #2;
    check("reset_outputs", {start_o, load_o, busy_o, done_o, err_o, req_ready_o, grant_o, data_o},
          16'h0000);
    do_reset();

    // --- single 1-byte packet 0xA5, vector table per cycle ---
    tbl[0]  = mk(2'b01, 2'b01, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tbl[1]  = mk(2'b01, 2'b01, 16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00);
    tbl[2]  = mk(2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'hA5);
    for (int i = 3; i <= 10; i++)
      tbl[i] = mk(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'hA5);
    tbl[11] = mk(2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
    tbl[12] = mk(2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'hA5);
    tbl[13] = mk(2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5);
    for (int i = 0; i < 14; i++) begin
      req_valid_i = tbl[i].v; req_last_i = tbl[i].l; req_data_i = tbl[i].d;
      check($sformatf("vec%0d", i),
            {16'd0, start_o, load_o, busy_o, done_o, err_o, req_ready_o, grant_o, data_o},
            {16'd0, tbl[i].exp});
      tick();
    end
    drive();

    // --- 3-byte packet, valid held: start high LOAD..last SHIFT = 9+10+10 ---
    tr.delete();
    q0.push_back(9'h011); q0.push_back(9'h022); q0.push_back(9'h133); drive();
    wait_loads(3, 60, "pkt3_timeout");
    repeat (14) tick_f();
    chk_load("pkt3_b0", 0, 1'b0, 8'h11);
    chk_load("pkt3_b1", 1, 1'b0, 8'h22);
    chk_load("pkt3_b2", 2, 1'b0, 8'h33);
    check("pkt3_load_gap1", 32'(nth_load(1) - nth_load(0)), 32'd10);
    check("pkt3_load_gap2", 32'(nth_load(2) - nth_load(1)), 32'd10);
    check("pkt3_start_run", 32'(run_len(nth_load(0))), 32'd29);
    idx = nth_load(0) + 29;
    check("pkt3_done", (idx < tr.size()) ? 32'(tr[idx].done) : 32'hFFFF, 32'd1);

    // --- two requesters, two 2-byte packets each: grant 0,1,0,1 ---
    do_reset();
    tr.delete(); n_bad_ready = 0;
    q0 = '{9'h001, 9'h102, 9'h003, 9'h104};
    q1 = '{9'h011, 9'h112, 9'h013, 9'h114};
    drive();
    repeat (110) tick_f();
    exp_d = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03, 8'h04, 8'h13, 8'h14};
    exp_g = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int n = 0; n < 8; n++) chk_load($sformatf("arb_load%0d", n), n, exp_g[n], exp_d[n]);
    check("arb_ready_onehot", 32'(n_bad_ready), 32'd0);

    // --- mid-packet stall of 5 FETCH cycles: resumes, no abort ---
    tr.delete();
    q0 = '{9'h05A, 9'h0C3, 9'h13C}; drive();
    wait_loads(1, 20, "stall_first_load");
    hold[0] = 1'b1; drive();
    wait_ready0(20, "stall_fetch_seen");
    repeat (5) tick_f();
    hold[0] = 1'b0; drive();
    wait_loads(3, 60, "stall_resume");
    repeat (12) tick_f();
    chk_load("stall_b1", 1, 1'b0, 8'hC3);
    chk_load("stall_b2", 2, 1'b0, 8'h3C);
    check("stall_load_pos", 32'(nth_load(1) - nth_load(0)), 32'd15);
    check("stall_start_run", 32'(run_len(nth_load(0))), 32'd34);
    nerr = 0;
    foreach (tr[i]) if (tr[i].err) nerr++;
    check("stall_no_err", 32'(nerr), 32'd0);

    // --- mid-packet stall of 16 cycles: abort, grant rotates ---
    tr.delete();
    q0 = '{9'h090, 9'h191}; drive();
    wait_loads(1, 20, "abort_first_load");
    hold[0] = 1'b1; drive();
    wait_ready0(20, "abort_fetch_seen");
    c0 = tr.size();
    repeat (17) tick_f();
    check("abort_start_before", {31'd0, tr[c0 + 15].start}, 32'd1);
    check("abort_err_pulse", {30'd0, tr[c0 + 16].err, tr[c0 + 15].err}, 32'd2);
    check("abort_start_low", {31'd0, tr[c0 + 16].start}, 32'd0);
    q1.push_back(9'h177); hold[0] = 1'b0; drive();
    wait_loads(3, 80, "abort_after");
    repeat (12) tick_f();
    chk_load("abort_next_owner", 1, 1'b1, 8'h77);
    chk_load("abort_then_req0", 2, 1'b0, 8'h91);

    // --- asynchronous reset during SHIFT of byte 2 ---
    tr.delete();
    q0 = '{9'h0A1, 9'h0A2, 9'h1A3}; drive();
    wait_loads(2, 40, "rst_loads");
    repeat (3) tick_f();
    check("rst_pre_busy", {31'd0, start_o}, 32'd1);
    areset_i = 1'b1;
    #1;
    check("rst_immediate", {start_o, load_o, busy_o, done_o, err_o, req_ready_o, grant_o, data_o},
          16'h0000);
    q0.delete(); q1.delete(); drive();
    tick(); tick();
    areset_i = 1'b0;
    tr.delete();
    q0.push_back(9'h1B0); q1.push_back(9'h1B1); drive();
    wait_loads(1, 20, "rst_restart");
    check("rst_restart_latency", 32'(nth_load(0)), 32'd2);
    chk_load("rst_restart_owner", 0, 1'b0, 8'hB0);
    repeat (30) tick_f();

    // --- GAP_CYCLES=1 back-to-back packets: 3 low cycles between ---
    g_valid = 2'b01; g_last = 2'b01; g_data = 16'h0042;
    tr.delete();
    repeat (60) tick();
    p = 0;
    while (p < tr.size() && !tr[p].g_start) p++;
    h = 0;  while (p < tr.size() &&  tr[p].g_start) begin h++;  p++; end
    z1 = 0; while (p < tr.size() && !tr[p].g_start) begin z1++; p++; end
    while (p < tr.size() && tr[p].g_start) p++;
    z2 = 0; while (p < tr.size() && !tr[p].g_start) begin z2++; p++; end
    check("gap1_high_run", 32'(h), 32'd9);
    check("gap1_low_a", 32'(z1), 32'd3);
    check("gap1_low_b", 32'(z2), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
